// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, one-byte holding register, valid/ready input.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 10416,
   parameter int unsigned CNT_W        = 14
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       tx_port
);

   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shifter_q, shifter_d;
   logic [7:0]       hold_q, hold_d;
   logic             hold_full_q, hold_full_d;
   logic             tx_ready_d, tx_busy_d, tx_port_d;
   logic             load_c;
`ifdef UART_TX_PARITY_EN
   logic             parity_q, parity_d;
`endif

   // State and output registers
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q     <= S_IDLE;
         timer_q     <= '0;
         bit_idx_q   <= '0;
         shifter_q   <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         tx_ready    <= 1'b1;
         tx_busy     <= 1'b0;
         tx_port     <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         bit_idx_q   <= bit_idx_d;
         shifter_q   <= shifter_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         tx_ready    <= tx_ready_d;
         tx_busy     <= tx_busy_d;
         tx_port     <= tx_port_d;
`ifdef UART_TX_PARITY_EN
         parity_q    <= parity_d;
`endif
      end
   end

   // Next-state, handshake and line-level logic
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      bit_idx_d   = bit_idx_q;
      shifter_d   = shifter_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      tx_ready_d  = tx_ready;
      tx_busy_d   = tx_busy;
      tx_port_d   = tx_port;
`ifdef UART_TX_PARITY_EN
      parity_d    = parity_q;
`endif
      load_c = hold_full_q &&
               ((state_q == S_IDLE) || ((state_q == S_STOP) && (timer_q == '0)));

      if (tx_valid && tx_ready) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
         tx_ready_d  = 1'b0;
      end

      case (state_q)
         S_IDLE: ;
         S_START: begin
            if (timer_q == '0) begin
               state_d   = S_DATA;
               timer_d   = BIT_LAST;
               bit_idx_d = 3'd0;
               tx_port_d = shifter_q[0];
            end else begin
               timer_d = timer_q - CNT_W'(1);
            end
         end
         S_DATA: begin
            if (timer_q == '0) begin
               timer_d = BIT_LAST;
               if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d   = S_PARITY;
                  tx_port_d = parity_q;
`else
                  state_d   = S_STOP;
                  tx_port_d = 1'b1;
`endif
               end else begin
                  shifter_d = {1'b0, shifter_q[7:1]};
                  tx_port_d = shifter_q[1];
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               timer_d = timer_q - CNT_W'(1);
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (timer_q == '0) begin
               state_d   = S_STOP;
               timer_d   = BIT_LAST;
               tx_port_d = 1'b1;
            end else begin
               timer_d = timer_q - CNT_W'(1);
            end
         end
`endif
         S_STOP: begin
            if (timer_q == '0) begin
               state_d   = S_IDLE;
               tx_busy_d = 1'b0;
            end else begin
               timer_d = timer_q - CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Shifter load from IDLE or the last stop cycle; overrides the stop-to-idle exit
      if (load_c) begin
         shifter_d   = hold_q;
         hold_full_d = 1'b0;
         tx_ready_d  = 1'b1;
         tx_port_d   = 1'b0;
         tx_busy_d   = 1'b1;
         timer_d     = BIT_LAST;
         state_d     = S_START;
`ifdef UART_TX_PARITY_EN
         parity_d    = ^hold_q;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx with CLKS_PER_BIT=4: a line monitor decodes frames and checks them
// against a scoreboard of accepted bytes; directed steps check handshake timing and reset.
module tb_uart_tx;

   localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int unsigned NB = 11;
`else
   localparam int unsigned NB = 10;
`endif
   localparam int unsigned FRAME = NB * CPB;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, tx_busy, tx_port;

   int n_chk = 0;
   int n_pass = 0;
   logic [7:0] sb[$];
   int busy_run = 0;
   int last_run = 0;
   logic prev_port = 1'b1;

   uart_tx #(.CLKS_PER_BIT(CPB), .CNT_W(3)) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .tx_data (tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .tx_busy (tx_busy),
      .tx_port (tx_port)
   );

   initial forever #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Busy run-length tracker
   always @(negedge sys_clk) begin
      if (tx_busy === 1'b1) begin
         busy_run <= busy_run + 1;
      end else begin
         if (busy_run != 0) last_run <= busy_run;
         busy_run <= 0;
      end
   end

   // Line monitor: every level must last CPB cycles; frame compared against scoreboard
   always begin
      logic [10:0] lv;
      logic        aborted, bad_width;
      logic [7:0]  e;
      @(negedge sys_clk);
      if (sys_rst === 1'b0 && prev_port === 1'b1 && tx_port === 1'b0) begin
         lv = '1;
         aborted = 1'b0;
         bad_width = 1'b0;
         for (int b = 0; b < int'(NB) && !aborted; b++) begin
            for (int c = 0; c < int'(CPB) && !aborted; c++) begin
               if (!(b == 0 && c == 0)) @(negedge sys_clk);
               if (sys_rst === 1'b1) aborted = 1'b1;
               else if (c == 0) lv[b] = tx_port;
               else if (tx_port !== lv[b]) bad_width = 1'b1;
            end
         end
         if (!aborted) begin
            chk("frame_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("bit_width", 32'(bad_width), 32'd0);
               chk("start_bit", 32'(lv[0]), 32'd0);
               chk("data_byte", 32'(lv[8:1]), 32'(e));
`ifdef UART_TX_PARITY_EN
               chk("parity_bit", 32'(lv[9]), 32'(^e));
`endif
               chk("stop_bit", 32'(lv[NB-1]), 32'd1);
            end
         end
      end
      prev_port = tx_port;
   end

   // Called at a negedge; returns at the negedge right after the accepting edge
   task automatic send(input logic [7:0] b);
      int n = 0;
      tx_valid = 1'b1;
      tx_data  = b;
      while (tx_ready !== 1'b1 && n < 400) begin
         @(negedge sys_clk);
         n++;
      end
      chk("accept_ready", 32'(tx_ready), 32'd1);
      @(negedge sys_clk);
      sb.push_back(b);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!(tx_busy === 1'b0 && sb.size() == 0) && n < 400) begin
         @(negedge sys_clk);
         n++;
      end
      chk("idle_reached", 32'(tx_busy), 32'd0);
      @(negedge sys_clk);
   endtask

   initial begin
      int bad;
      // 1: reset, then quiet line
      repeat (2) @(negedge sys_clk);
      sys_rst = 1'b0;
      chk("rst_port", 32'(tx_port), 32'd1);
      chk("rst_ready", 32'(tx_ready), 32'd1);
      chk("rst_busy", 32'(tx_busy), 32'd0);
      bad = 0;
      repeat (100) begin
         @(negedge sys_clk);
         if (tx_port !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) bad++;
      end
      chk("idle_hold", 32'(bad), 32'd0);

      // 2: 0xA5 from idle, latency and frame length
      send(8'hA5);
      tx_valid = 1'b0;
      chk("acc_ready_low", 32'(tx_ready), 32'd0);
      chk("acc_port_idle", 32'(tx_port), 32'd1);
      @(negedge sys_clk);
      chk("load_ready", 32'(tx_ready), 32'd1);
      chk("load_start", 32'(tx_port), 32'd0);
      chk("load_busy", 32'(tx_busy), 32'd1);
      wait_idle();
      chk("busy_len_a5", 32'(last_run), 32'(FRAME));

      // 3: back-to-back 0x3C, 0xFF with tx_valid held
      send(8'h3C);
      send(8'hFF);
      tx_valid = 1'b0;
      wait_idle();
      chk("busy_len_b2b", 32'(last_run), 32'(2 * FRAME));

      // 4: data changed while tx_ready=0; only the accepted value goes out
      send(8'h81);
      send(8'h42);
      tx_data = 8'h99;
      bad = 0;
      repeat (5) begin
         @(negedge sys_clk);
         if (tx_ready !== 1'b0) bad++;
      end
      chk("held_not_ready", 32'(bad), 32'd0);
      send(8'h5A);
      tx_valid = 1'b0;
      wait_idle();

      // 5: reset during data bit 3 of 0x00 with 0x55 held
      send(8'h00);
      send(8'h55);
      tx_valid = 1'b0;
      repeat (16) @(negedge sys_clk);
      chk("pre_rst_busy", 32'(tx_busy), 32'd1);
      sys_rst = 1'b1;
      @(negedge sys_clk);
      chk("abort_port", 32'(tx_port), 32'd1);
      chk("abort_busy", 32'(tx_busy), 32'd0);
      chk("abort_ready", 32'(tx_ready), 32'd1);
      sb.delete();
      sys_rst = 1'b0;
      bad = 0;
      repeat (60) begin
         @(negedge sys_clk);
         if (tx_port !== 1'b1 || tx_busy !== 1'b0) bad++;
      end
      chk("no_frame_after_rst", 32'(bad), 32'd0);

`ifdef UART_TX_PARITY_EN
      // 6: parity frames are 44 cycles
      send(8'hA5);
      tx_valid = 1'b0;
      wait_idle();
      chk("par_len_a5", 32'(last_run), 32'd44);
      send(8'h01);
      tx_valid = 1'b0;
      wait_idle();
      chk("par_len_01", 32'(last_run), 32'd44);
`endif

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
